axi_lite_master_bridge: RTL and testbench

Parametrised bridge that connects the CPU core's two memory ports (instruction fetch and data load/store) to a single AXI4-Lite master interface. It replaces direct ROM/RAM wiring at the SoC top level and adds a request/done handshake, so the core stalls on slow slaves. It arbitrates between the two ports, runs one AXI4-Lite transaction at a time and reports slave errors.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_master_bridge_if.sv | 40 ++++
 rtl/axi_lite_arbiter.sv | 29 ++
 rtl/axi_lite_master_bridge.sv | 120 ++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the bridge FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_INST = 3'b100;
    localparam logic [2:0] PROT_DATA = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AWW,
        B,
        DONE
    } state_t;

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite bus bundle; the bridge connects through the master modport.
interface axi_lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [2:0]            m_awprot;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [STRB_WIDTH-1:0] m_wstrb;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [2:0]            m_arprot;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rvalid;
    logic                  m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
               m_araddr, m_arprot, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
               m_araddr, m_arprot, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
    );

endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-way grant between fetch and data ports with a last-grant register.
module axi_lite_arbiter #(
    parameter int ARB_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req,
    input  logic data_req,
    input  logic take,
    output logic gnt_data
);

    logic last_data;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        gnt_data = data_req;
        if (ARB_MODE == 1 && inst_req && data_req)
            gnt_data = ~last_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_data <= 1'b0;
        else if (take)
            last_data <= gnt_data;
    end

endmodule

// File: rtl/axi_lite_master_bridge.sv
// Bridges the core fetch and load/store ports onto one AXI4-Lite master, one transaction at a time.
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic [DATA_WIDTH-1:0] inst_rdata_o,
    output logic                  inst_done_o,
    output logic                  inst_err_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [STRB_WIDTH-1:0] data_sel_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_done_o,
    output logic                  data_err_o,
    axi_lite_master_bridge_if.master axi
);

    state_t                state, state_nxt;
    logic                  gnt_data, any_req, take;
    logic                  port_data, aw_done, w_done, err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] sel;

    assign any_req = inst_req_i | data_req_i;
    assign take    = (state == IDLE) && any_req;

    axi_lite_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .inst_req (inst_req_i),
        .data_req (data_req_i),
        .take     (take),
        .gnt_data (gnt_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // AW and W move independently; B is entered once both have been accepted.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any_req) state_nxt = (gnt_data && data_we_i) ? AWW : AR;
            AR:   if (axi.m_arready) state_nxt = R;
            R:    if (axi.m_rvalid) state_nxt = DONE;
            AWW:  if ((aw_done || axi.m_awready) && (w_done || axi.m_wready)) state_nxt = B;
            B:    if (axi.m_bvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_data    <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            sel          <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            err          <= 1'b0;
            inst_rdata_o <= '0;
            data_rdata_o <= '0;
        end else begin
            unique case (state)
                IDLE: if (any_req) begin
                    port_data <= gnt_data;
                    addr      <= gnt_data ? data_addr_i : inst_addr_i;
                    wdata     <= gnt_data ? data_wdata_i : '0;
                    sel       <= gnt_data ? data_sel_i : '0;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    err       <= 1'b0;
                end
                R: if (axi.m_rvalid) begin
                    err <= (axi.m_rresp != RESP_OKAY);
                    if (port_data) data_rdata_o <= axi.m_rdata;
                    else           inst_rdata_o <= axi.m_rdata;
                end
                AWW: begin
                    if (axi.m_awvalid && axi.m_awready) aw_done <= 1'b1;
                    if (axi.m_wvalid && axi.m_wready)   w_done  <= 1'b1;
                end
                B: if (axi.m_bvalid) err <= (axi.m_bresp != RESP_OKAY);
                default: ;
            endcase
        end
    end

    assign axi.m_araddr  = addr;
    assign axi.m_arprot  = port_data ? PROT_DATA : PROT_INST;
    assign axi.m_arvalid = (state == AR);
    assign axi.m_rready  = (state == R);
    assign axi.m_awaddr  = addr;
    assign axi.m_awprot  = PROT_DATA;
    assign axi.m_awvalid = (state == AWW) && !aw_done;
    assign axi.m_wdata   = wdata;
    assign axi.m_wstrb   = sel;
    assign axi.m_wvalid  = (state == AWW) && !w_done;
    assign axi.m_bready  = (state == B);

    assign inst_done_o = (state == DONE) && !port_data;
    assign data_done_o = (state == DONE) && port_data;
    assign inst_err_o  = inst_done_o && err;
    assign data_err_o  = data_done_o && err;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench: fixed-priority bridge on a hand-driven slave, round-robin bridge on an auto slave.
module tb_axi_lite_master_bridge;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fixed-priority instance
    logic        inst_req0 = 0, data_req0 = 0, data_we0 = 0;
    logic [31:0] inst_addr0 = 0, data_addr0 = 0, data_wdata0 = 0;
    logic [3:0]  data_sel0 = 0;
    logic [31:0] inst_rdata0, data_rdata0;
    logic        inst_done0, inst_err0, data_done0, data_err0;
    axi_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi0 ();

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req0), .inst_addr_i(inst_addr0), .inst_rdata_o(inst_rdata0),
        .inst_done_o(inst_done0), .inst_err_o(inst_err0),
        .data_req_i(data_req0), .data_we_i(data_we0), .data_sel_i(data_sel0),
        .data_addr_i(data_addr0), .data_wdata_i(data_wdata0), .data_rdata_o(data_rdata0),
        .data_done_o(data_done0), .data_err_o(data_err0),
        .axi(axi0.master)
    );

    // round-robin instance
    logic        inst_req1 = 0, data_req1 = 0, data_we1 = 0;
    logic [31:0] inst_addr1 = 0, data_addr1 = 0, data_wdata1 = 0;
    logic [3:0]  data_sel1 = 0;
    logic [31:0] inst_rdata1, data_rdata1;
    logic        inst_done1, inst_err1, data_done1, data_err1;
    axi_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi1 ();

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req1), .inst_addr_i(inst_addr1), .inst_rdata_o(inst_rdata1),
        .inst_done_o(inst_done1), .inst_err_o(inst_err1),
        .data_req_i(data_req1), .data_we_i(data_we1), .data_sel_i(data_sel1),
        .data_addr_i(data_addr1), .data_wdata_i(data_wdata1), .data_rdata_o(data_rdata1),
        .data_done_o(data_done1), .data_err_o(data_err1),
        .axi(axi1.master)
    );

    // zero-wait slave for the round-robin instance: returns the read address as data
    assign axi1.m_arready = 1'b1;
    assign axi1.m_awready = 1'b1;
    assign axi1.m_wready  = 1'b1;
    assign axi1.m_rresp   = RESP_OKAY;
    assign axi1.m_bresp   = RESP_OKAY;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            axi1.m_rvalid <= 1'b0;
            axi1.m_rdata  <= '0;
            axi1.m_bvalid <= 1'b0;
        end else begin
            if (axi1.m_arvalid && !axi1.m_rvalid) begin
                axi1.m_rvalid <= 1'b1;
                axi1.m_rdata  <= axi1.m_araddr;
            end else if (axi1.m_rvalid && axi1.m_rready) begin
                axi1.m_rvalid <= 1'b0;
            end
            if (axi1.m_awvalid && axi1.m_wvalid) axi1.m_bvalid <= 1'b1;
            else if (axi1.m_bvalid && axi1.m_bready) axi1.m_bvalid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int t1, t2;
    int order[$];

    initial begin
        axi0.m_arready = 0; axi0.m_rvalid = 0; axi0.m_rdata = 0; axi0.m_rresp = 0;
        axi0.m_awready = 0; axi0.m_wready = 0; axi0.m_bvalid = 0; axi0.m_bresp = 0;

        // reset state
        tick(); tick();
        chk("rst_arvalid", axi0.m_arvalid, 0);
        chk("rst_awvalid", axi0.m_awvalid, 0);
        chk("rst_wvalid",  axi0.m_wvalid, 0);
        chk("rst_rready",  axi0.m_rready, 0);
        chk("rst_bready",  axi0.m_bready, 0);
        chk("rst_dones",   {inst_done0, data_done0, inst_err0, data_err0}, 0);
        chk("rst_rdata",   {inst_rdata0, data_rdata0}, 0);
        rst = 1;
        tick();

        // zero-wait fetch: done 3 cycles after the request is sampled
        inst_req0 = 1; inst_addr0 = 32'h0000_0040; axi0.m_arready = 1;
        tick();
        chk("rd_arvalid", axi0.m_arvalid, 1);
        chk("rd_araddr",  axi0.m_araddr, 32'h40);
        chk("rd_arprot",  axi0.m_arprot, 3'b100);
        axi0.m_rvalid = 1; axi0.m_rdata = 32'h2402_0001; axi0.m_rresp = RESP_OKAY;
        tick();
        chk("rd_rready",   axi0.m_rready, 1);
        chk("rd_ar_drop",  axi0.m_arvalid, 0);
        chk("rd_early_dn", inst_done0, 0);
        tick();
        chk("rd_done",  inst_done0, 1);
        chk("rd_rdata", inst_rdata0, 32'h2402_0001);
        chk("rd_err",   inst_err0, 0);
        inst_req0 = 0; axi0.m_rvalid = 0;
        tick();
        chk("rd_done_pulse", inst_done0, 0);
        chk("rd_rdata_hold", inst_rdata0, 32'h2402_0001);

        // tie with fixed priority: data load first, fetch next
        inst_req0 = 1; inst_addr0 = 32'h80;
        data_req0 = 1; data_we0 = 0; data_addr0 = 32'h300;
        tick();
        chk("tie0_addr1", axi0.m_araddr, 32'h300);
        chk("tie0_prot1", axi0.m_arprot, 3'b000);
        axi0.m_rvalid = 1; axi0.m_rdata = 32'h1111_1111;
        tick(); tick();
        chk("tie0_ddone", {data_done0, inst_done0}, 2'b10);
        chk("tie0_drdata", data_rdata0, 32'h1111_1111);
        data_req0 = 0; axi0.m_rvalid = 0;
        tick(); tick();
        chk("tie0_addr2", axi0.m_araddr, 32'h80);
        chk("tie0_prot2", axi0.m_arprot, 3'b100);
        axi0.m_rvalid = 1; axi0.m_rdata = 32'h2222_2222;
        tick(); tick();
        chk("tie0_idone", {data_done0, inst_done0}, 2'b01);
        chk("tie0_irdata", inst_rdata0, 32'h2222_2222);
        chk("tie0_dkeep", data_rdata0, 32'h1111_1111);
        inst_req0 = 0; axi0.m_rvalid = 0; axi0.m_arready = 0;
        tick();

        // store: wready two cycles ahead of awready, one B wait, SLVERR
        data_req0 = 1; data_we0 = 1; data_addr0 = 32'h100;
        data_wdata0 = 32'hDEAD_BEEF; data_sel0 = 4'b0011;
        tick();
        chk("st_valids1", {axi0.m_awvalid, axi0.m_wvalid}, 2'b11);
        chk("st_wstrb1",  axi0.m_wstrb, 4'b0011);
        chk("st_wdata",   axi0.m_wdata, 32'hDEAD_BEEF);
        axi0.m_wready = 1;
        tick();
        chk("st_valids2", {axi0.m_awvalid, axi0.m_wvalid}, 2'b10);
        chk("st_awaddr",  axi0.m_awaddr, 32'h100);
        axi0.m_wready = 0;
        tick();
        chk("st_valids3", {axi0.m_awvalid, axi0.m_wvalid}, 2'b10);
        chk("st_wstrb3",  axi0.m_wstrb, 4'b0011);
        axi0.m_awready = 1;
        tick();
        chk("st_b_state", {axi0.m_awvalid, axi0.m_wvalid, axi0.m_bready}, 3'b001);
        axi0.m_awready = 0;
        tick();
        chk("st_b_wait", {axi0.m_bready, data_done0}, 2'b10);
        axi0.m_bvalid = 1; axi0.m_bresp = RESP_SLVERR;
        tick();
        chk("st_done", {data_done0, data_err0, inst_done0}, 3'b110);
        chk("st_rdata_keep", data_rdata0, 32'h1111_1111);
        data_req0 = 0; data_we0 = 0; axi0.m_bvalid = 0;
        tick();
        chk("st_after", {axi0.m_bready, data_done0, data_err0}, 3'b000);

        // reset while waiting in R
        inst_req0 = 1; inst_addr0 = 32'h40; axi0.m_arready = 1;
        tick(); tick();
        chk("mr_in_r", axi0.m_rready, 1);
        rst = 0;
        #1;
        chk("mr_ready",  {axi0.m_arvalid, axi0.m_rready}, 2'b00);
        chk("mr_done",   inst_done0, 0);
        chk("mr_state",  dut0.state, IDLE);
        chk("mr_rdata",  inst_rdata0, 32'h0);
        inst_req0 = 0;
        tick();
        chk("mr_nodone", inst_done0, 0);
        rst = 1;
        tick();

        // back-to-back loads, done pulses 4 cycles apart
        data_req0 = 1; data_we0 = 0; data_addr0 = 32'h200;
        tick();
        axi0.m_rvalid = 1; axi0.m_rdata = 32'hA5A5_0200;
        tick(); tick();
        chk("bb_done1", data_done0, 1);
        chk("bb_data1", data_rdata0, 32'hA5A5_0200);
        t1 = cyc;
        data_addr0 = 32'h204; axi0.m_rvalid = 0;
        tick(); tick();
        chk("bb_addr2", axi0.m_araddr, 32'h204);
        axi0.m_rvalid = 1; axi0.m_rdata = 32'h5A5A_0204;
        tick(); tick();
        t2 = cyc;
        chk("bb_done2", data_done0, 1);
        chk("bb_data2", data_rdata0, 32'h5A5A_0204);
        chk("bb_gap", t2 - t1, 4);
        data_req0 = 0; axi0.m_rvalid = 0;
        tick();

        // round-robin: persistent tie alternates data, inst, data
        inst_req1 = 1; inst_addr1 = 32'h1000;
        data_req1 = 1; data_we1 = 0; data_addr1 = 32'h2000;
        for (int i = 0; i < 40 && order.size() < 3; i++) begin
            tick();
            if (data_done1) begin
                order.push_back(1);
                chk("rr_drdata", data_rdata1, 32'h2000);
            end
            if (inst_done1) begin
                order.push_back(0);
                chk("rr_irdata", inst_rdata1, 32'h1000);
            end
        end
        chk("rr_count", order.size(), 3);
        while (order.size() < 3) order.push_back(2);
        chk("rr_first",  order[0], 1);
        chk("rr_second", order[1], 0);
        chk("rr_third",  order[2], 1);
        inst_req1 = 0; data_req1 = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
